// File: rtl/laser_cover_scorer.sv
// laser_cover_scorer: stores a 40-point X/Y frame, latches two circle centres on a
// DONE rising edge, then counts the stored points that fall inside either radius-4 circle.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   PT_VALID, X, Y    snooped point stream (4-bit coordinates)
//   DONE              engine result-ready level (only its 0->1 edge is used)
//   C1X..C2Y          circle centres, sampled on the DONE edge cycle
//   SCORE             covered-point count (held between reports)
//   SCORE_VALID       one-cycle pulse while a new SCORE/ERR is presented
//   ERR               frame error: short frame or extra points
//   BUSY              high whenever a frame is in progress
module laser_cover_scorer #(
    parameter int NPTS      = 40,
    parameter int RADIUS_SQ = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PT_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic [5:0] SCORE,
    output logic       SCORE_VALID,
    output logic       ERR,
    output logic       BUSY
);

    localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
    localparam logic [8:0] R_SQ     = 9'(RADIUS_SQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_EVAL,
        S_REPORT
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] pcnt_q, pcnt_d;
    logic [5:0] eidx_q, eidx_d;
    logic [5:0] acc_q, acc_d;
    logic       done_d_q, done_d_d;
    logic       err_short_q, err_short_d;
    logic       err_ovf_q, err_ovf_d;
    logic [3:0] c1x_q, c1x_d, c1y_q, c1y_d;
    logic [3:0] c2x_q, c2x_d, c2y_q, c2y_d;
    logic [5:0] score_q, score_d;
    logic       score_valid_q, score_valid_d;
    logic       err_q, err_d;

    logic [7:0] mem_q [NPTS];
    logic       mem_we;
    logic [5:0] mem_wa;
    logic [7:0] mem_wd;

    logic       done_edge;
    logic       latch_c;
    logic [7:0] pt_rd;
    logic [8:0] d1, d2;
    logic       hit;

    // Squared distance; the difference is taken on 5-bit signed so it never wraps.
    function automatic logic [8:0] dist_sq(
        input logic [3:0] px, input logic [3:0] py,
        input logic [3:0] cx, input logic [3:0] cy
    );
        logic signed [4:0] dx, dy;
        logic [3:0] ax, ay;
        logic [7:0] sx, sy;
        dx = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy = $signed({1'b0, py}) - $signed({1'b0, cy});
        ax = (dx < 0) ? 4'(-dx) : 4'(dx);
        ay = (dy < 0) ? 4'(-dy) : 4'(dy);
        sx = {4'd0, ax} * {4'd0, ax};
        sy = {4'd0, ay} * {4'd0, ay};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    assign done_edge = DONE & ~done_d_q;
    assign pt_rd     = mem_q[eidx_q];
    assign d1        = dist_sq(pt_rd[7:4], pt_rd[3:0], c1x_q, c1y_q);
    assign d2        = dist_sq(pt_rd[7:4], pt_rd[3:0], c2x_q, c2y_q);
    // A point inside both circles still counts once.
    assign hit       = (d1 <= R_SQ) | (d2 <= R_SQ);

    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        eidx_d        = eidx_q;
        acc_d         = acc_q;
        done_d_d      = DONE;
        err_short_d   = err_short_q;
        err_ovf_d     = err_ovf_q;
        score_d       = score_q;
        score_valid_d = 1'b0;
        err_d         = err_q;
        latch_c       = 1'b0;
        mem_we        = 1'b0;
        mem_wa        = pcnt_q;
        mem_wd        = {X, Y};

        unique case (state_q)
            S_IDLE: begin
                if (PT_VALID) begin
                    mem_we  = 1'b1;
                    mem_wa  = 6'd0;
                    pcnt_d  = 6'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (done_edge) begin
                    latch_c     = 1'b1;
                    err_short_d = 1'b1;
                    eidx_d      = 6'd0;
                    acc_d       = 6'd0;
                    state_d     = S_EVAL;
                end else if (PT_VALID) begin
                    mem_we = 1'b1;
                    pcnt_d = pcnt_q + 6'd1;
                    if (pcnt_q == LAST_IDX) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (PT_VALID) begin
                    err_ovf_d = 1'b1;
                end
                if (done_edge) begin
                    latch_c = 1'b1;
                    eidx_d  = 6'd0;
                    acc_d   = 6'd0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (PT_VALID) begin
                    err_ovf_d = 1'b1;
                end
                acc_d  = acc_q + 6'(hit);
                eidx_d = eidx_q + 6'd1;
                // Result is registered on the last point so it is visible
                // for the whole REPORT cycle.
                if (eidx_q == pcnt_q - 6'd1) begin
                    score_d       = acc_d;
                    err_d         = err_short_q | err_ovf_d;
                    score_valid_d = 1'b1;
                    state_d       = S_REPORT;
                end
            end
            S_REPORT: begin
                pcnt_d      = 6'd0;
                err_short_d = 1'b0;
                err_ovf_d   = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign c1x_d = latch_c ? C1X : c1x_q;
    assign c1y_d = latch_c ? C1Y : c1y_q;
    assign c2x_d = latch_c ? C2X : c2x_q;
    assign c2y_d = latch_c ? C2Y : c2y_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            pcnt_q        <= 6'd0;
            eidx_q        <= 6'd0;
            acc_q         <= 6'd0;
            done_d_q      <= 1'b1;
            err_short_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
            c1x_q         <= 4'd0;
            c1y_q         <= 4'd0;
            c2x_q         <= 4'd0;
            c2y_q         <= 4'd0;
            score_q       <= 6'd0;
            score_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            eidx_q        <= eidx_d;
            acc_q         <= acc_d;
            done_d_q      <= done_d_d;
            err_short_q   <= err_short_d;
            err_ovf_q     <= err_ovf_d;
            c1x_q         <= c1x_d;
            c1y_q         <= c1y_d;
            c2x_q         <= c2x_d;
            c2y_q         <= c2y_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign SCORE       = score_q;
    assign SCORE_VALID = score_valid_q;
    assign ERR         = err_q;
    assign BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_laser_cover_scorer.sv
// tb_laser_cover_scorer: scoreboard bench for laser_cover_scorer.
// Expected reports are queued when DONE is driven and popped on SCORE_VALID.
module tb_laser_cover_scorer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PT_VALID;
    logic [3:0] X, Y;
    logic       DONE;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic [5:0] SCORE;
    logic       SCORE_VALID;
    logic       ERR;
    logic       BUSY;

    laser_cover_scorer dut (
        .CLK        (CLK),
        .RST        (RST),
        .PT_VALID   (PT_VALID),
        .X          (X),
        .Y          (Y),
        .DONE       (DONE),
        .C1X        (C1X),
        .C1Y        (C1Y),
        .C2X        (C2X),
        .C2Y        (C2Y),
        .SCORE      (SCORE),
        .SCORE_VALID(SCORE_VALID),
        .ERR        (ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int score;
        int err;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   px_a[40];
    int   py_a[40];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (SCORE_VALID) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("score", int'(SCORE), e.score);
                    check("err", int'(ERR), e.err);
                    check("latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send_pt(input int x, input int y);
        @(negedge CLK);
        PT_VALID = 1'b1;
        X = 4'(x);
        Y = 4'(y);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            PT_VALID = 1'b0;
        end
    endtask

    task automatic stream(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) send_pt(x, y);
        idle(1);
    endtask

    // Raise DONE for one cycle; DONE is sampled on the next rising edge,
    // so the report is expected n+1 edges after the current count.
    task automatic fire(input int c1x, input int c1y, input int c2x, input int c2y,
                        input int n, input int sc, input int er);
        @(negedge CLK);
        PT_VALID = 1'b0;
        C1X = 4'(c1x);
        C1Y = 4'(c1y);
        C2X = 4'(c2x);
        C2Y = 4'(c2y);
        DONE = 1'b1;
        sb.push_back('{sc, er, cyc + 1 + n});
        @(negedge CLK);
        DONE = 1'b0;
        C1X = 4'hF;
        C1Y = 4'h3;
        C2X = 4'h9;
        C2Y = 4'hC;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (sb.size() != 0) begin
            check("report_timeout", sb.size(), 0);
            sb.delete();
        end
        idle(2);
    endtask

    function automatic int model(input int n, input int c1x, input int c1y,
                                 input int c2x, input int c2y);
        int cnt, a, b;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            a = (px_a[i] - c1x) ** 2 + (py_a[i] - c1y) ** 2;
            b = (px_a[i] - c2x) ** 2 + (py_a[i] - c2y) ** 2;
            if (a <= 16 || b <= 16) cnt++;
        end
        return cnt;
    endfunction

    task automatic random_frame(input int n);
        int c1x, c1y, c2x, c2y, sc;
        for (int i = 0; i < n; i++) begin
            px_a[i] = int'($urandom_range(15));
            py_a[i] = int'($urandom_range(15));
            send_pt(px_a[i], py_a[i]);
        end
        idle(1);
        c1x = int'($urandom_range(15));
        c1y = int'($urandom_range(15));
        c2x = int'($urandom_range(15));
        c2y = int'($urandom_range(15));
        sc  = model(n, c1x, c1y, c2x, c2y);
        fire(c1x, c1y, c2x, c2y, n, sc, (n < 40) ? 1 : 0);
        drain();
    endtask

    initial begin
        RST = 1'b1;
        DONE = 1'b1;
        PT_VALID = 1'b0;
        X = 4'd0;
        Y = 4'd0;
        C1X = 4'd0;
        C1Y = 4'd0;
        C2X = 4'd0;
        C2Y = 4'd0;
        repeat (3) @(negedge CLK);
        check("rst_score", int'(SCORE), 0);
        check("rst_valid", int'(SCORE_VALID), 0);
        check("rst_err", int'(ERR), 0);
        check("rst_busy", int'(BUSY), 0);

        // DONE already high at reset release must never trigger.
        RST = 1'b0;
        send_pt(8, 8);
        @(negedge CLK);
        PT_VALID = 1'b0;
        check("busy_load", int'(BUSY), 1);
        stream(39, 8, 8);
        idle(50);
        check("busy_wait", int'(BUSY), 1);
        DONE = 1'b0;
        idle(2);
        fire(8, 8, 0, 0, 40, 40, 0);
        drain();
        check("busy_idle", int'(BUSY), 0);

        // Full frame, all covered.
        stream(40, 8, 8);
        fire(8, 8, 0, 0, 40, 40, 0);
        drain();

        // Radius boundary: 16 inside, 18 outside.
        stream(20, 0, 0);
        stream(20, 15, 15);
        fire(4, 0, 12, 12, 40, 20, 0);
        drain();
        stream(20, 0, 0);
        stream(20, 15, 15);
        fire(4, 0, 15, 11, 40, 40, 0);
        drain();

        // Overlapping circles count each point once.
        stream(40, 5, 5);
        fire(5, 5, 5, 5, 40, 40, 0);
        drain();

        // Short frame.
        stream(10, 1, 1);
        fire(1, 1, 15, 0, 10, 10, 1);
        drain();

        // Extra point while waiting for DONE.
        stream(41, 8, 8);
        fire(8, 8, 0, 0, 40, 40, 1);
        drain();

        // Reset in the middle of evaluation.
        stream(40, 3, 3);
        @(negedge CLK);
        C1X = 4'd3;
        C1Y = 4'd3;
        DONE = 1'b1;
        @(negedge CLK);
        DONE = 1'b0;
        repeat (19) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_score", int'(SCORE), 0);
        check("mid_rst_valid", int'(SCORE_VALID), 0);
        check("mid_rst_err", int'(ERR), 0);
        check("mid_rst_busy", int'(BUSY), 0);
        RST = 1'b0;
        idle(50);

        // Following frames score normally.
        random_frame(40);
        random_frame(40);
        random_frame(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
